// File: rtl/mpadd_seq.sv
// mpadd_seq: multi-word adder that runs a single 32-bit prefix adder once per word.
// Define MPADD_SUB_EN to add the sub input, which selects A-B instead of A+B+cin.
module PrefixAdder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] p0, g0, g1, g2, g3, g4, g5;
  logic [31:2]  p1;
  logic [31:4]  p2;
  logic [31:8]  p3;
  logic [31:16] p4;

  assign p0 = a ^ b;
  // Fold cin into bit 0's generate so each prefix group ending at bit 0 is a carry
  assign g0 = (a & b) | {31'b0, p0[0] & cin};

  for (genvar i = 0; i < 32; i++) begin : g_bit
    if (i >= 1)  begin : g_l1 assign g1[i] = g0[i] | (p0[i] & g0[i-1]);  end
    else         begin : g_p1 assign g1[i] = g0[i]; end
    if (i >= 2)  begin : g_q1 assign p1[i] = p0[i] & p0[i-1]; end
    if (i >= 2)  begin : g_l2 assign g2[i] = g1[i] | (p1[i] & g1[i-2]);  end
    else         begin : g_p2 assign g2[i] = g1[i]; end
    if (i >= 4)  begin : g_q2 assign p2[i] = p1[i] & p1[i-2]; end
    if (i >= 4)  begin : g_l3 assign g3[i] = g2[i] | (p2[i] & g2[i-4]);  end
    else         begin : g_p3 assign g3[i] = g2[i]; end
    if (i >= 8)  begin : g_q3 assign p3[i] = p2[i] & p2[i-4]; end
    if (i >= 8)  begin : g_l4 assign g4[i] = g3[i] | (p3[i] & g3[i-8]);  end
    else         begin : g_p4 assign g4[i] = g3[i]; end
    if (i >= 16) begin : g_q4 assign p4[i] = p3[i] & p3[i-8]; end
    if (i >= 16) begin : g_l5 assign g5[i] = g4[i] | (p4[i] & g4[i-16]); end
    else         begin : g_p5 assign g5[i] = g4[i]; end
  end

  assign sum  = p0 ^ {g5[30:0], cin};
  assign cout = g5[31];
endmodule

module mpadd_seq #(
  parameter int NWORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NWORDS-1:0]  a,
  input  logic [32*NWORDS-1:0]  b,
  input  logic                  cin,
`ifdef MPADD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NWORDS-1:0]  sum,
  output logic                  cout
);
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int W  = 32 * NWORDS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d, cout_q, cout_d;
  logic [31:0]   wa, wb, ws;
  logic          wc;

  assign wa = a_q[{idx_q, 5'b0} +: 32];
`ifdef MPADD_SUB_EN
  logic sub_q, sub_d;
  assign wb = b_q[{idx_q, 5'b0} +: 32] ^ {32{sub_q}};
`else
  assign wb = b_q[{idx_q, 5'b0} +: 32];
`endif

  PrefixAdder u_add (.a(wa), .b(wb), .cin(carry_q), .sum(ws), .cout(wc));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef MPADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
`ifdef MPADD_SUB_EN
        sub_d   = sub;
        if (sub) carry_d = 1'b1;
`endif
        idx_d   = '0;
        sum_d   = '0;
        cout_d  = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[{idx_q, 5'b0} +: 32] = ws;
        carry_d = wc;
        if (idx_q == IW'(NWORDS - 1)) begin
          cout_d  = wc;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef MPADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef MPADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: doc/mpadd_seq.md
MPADD_SEQ -- requirements
Module: mpadd_seq

Interface
REQ-001 Parameter: NWORDS, 4, number of 32-bit words per operand (2..16).
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operand set offered.
REQ-005 Port: in_ready  output  1  block accepts operands this cycle.
REQ-006 Port: a  input  32*NWORDS  operand A, word 0 = bits [31:0].
REQ-007 Port: b  input  32*NWORDS  operand B, same layout.
REQ-008 Port: cin  input  1  carry into word 0.
REQ-009 Port: sub  input  1  subtract request (present only with MPADD_SUB_EN).
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer takes result.
REQ-012 Port: sum  output  32*NWORDS  result, registered.
REQ-013 Port: cout  output  1  carry out of top word, registered.

Function
REQ-014 Block SHALL instantiate exactly one PrefixAdder (32-bit a, b, cin -> sum, cout) and reuse it once per word; no other adder on the datapath.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on in_valid&&in_ready, RUN->DONE after word NWORDS-1 processed, DONE->IDLE on out_valid&&out_ready.
REQ-016 in_ready SHALL be 1 only in IDLE; in_valid in RUN/DONE is ignored (not latched).
REQ-017 On accept, a, b, cin (and sub) SHALL be latched; word index reset to 0; carry register loaded with cin.
REQ-018 Each RUN cycle SHALL add word[idx] of latched A and B with carry register, write PrefixAdder sum into sum word[idx], load carry register with PrefixAdder cout, increment idx.
REQ-019 Word index SHALL be ceil(log2(NWORDS)) bits wide; no wrap past NWORDS-1 (FSM exits first).
REQ-020 out_valid SHALL rise exactly NWORDS cycles after the accept edge and stay 1 with sum/cout stable until out_ready sampled 1.
REQ-021 cout SHALL equal the carry register after the final word; sum words not yet processed SHALL read 0 during RUN.
REQ-022 Result SHALL equal (A + B + cin) mod 2^(32*NWORDS), cout = bit 32*NWORDS of the full sum.
REQ-023 Throughput SHALL be one operation per NWORDS+2 cycles minimum (accept, NWORDS RUN, DONE handshake, back to IDLE).
REQ-024 out_ready while not in DONE SHALL have no effect.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, cout=0, idx=0, carry=0, latched operands=0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no partial result ever presented.
REQ-027 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro MPADD_SUB_EN: when defined, sub port exists; sub=1 latched at accept SHALL feed ~B words to the adder and force initial carry to 1 (cin ignored), giving A-B; cout=1 means no borrow.
REQ-029 Without MPADD_SUB_EN, sub port SHALL be absent and the block SHALL only add; logic otherwise identical.

Verification (NWORDS=4)
REQ-030 A=1, B=1, cin=0 -> out_valid 4 cycles after accept, sum=...0002, cout=0.
REQ-031 A=all-ones (128 bits), B=1, cin=0 -> sum=0, cout=1; carry ripples through all four words.
REQ-032 A=0x00000000_00000000_00000000_FFFFFFFF, B=0, cin=1 -> sum=0x...00000001_00000000, cout=0.
REQ-033 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> sum/cout stable, in_ready=0, no new accept; release -> IDLE next edge, then accept.
REQ-034 Assert rst_n=0 in the second RUN cycle -> out_valid=0, sum=0 immediately; new operation after reset completes correctly.
REQ-035 With MPADD_SUB_EN: A=5, B=7, sub=1 -> sum=all-ones minus 1 (−2), cout=0; A=7, B=5 -> sum=2, cout=1.
